// File: rtl/dcache_if.sv
// dcache_if: CPU-side and memory-side bus bundle for dcache_ctrl.
// slave  = the cache controller, master = pipeline + memory side (or a bench).
interface dcache_if #(
  parameter int LINE_WORDS = 4
);
  // CPU side (MEM stage)
  logic [31:0]              cpu_addr;
  logic [31:0]              cpu_wdata;
  logic [3:0]               cpu_byteen;
  logic                     cpu_read;
  logic                     cpu_write;
  logic [31:0]              cpu_rdata;
  logic                     gen_stall;
  // line-wide memory side
  logic                     mem_req;
  logic                     mem_we;
  logic [31:0]              mem_addr;
  logic [32*LINE_WORDS-1:0] mem_wdata;
  logic [32*LINE_WORDS-1:0] mem_rdata;
  logic                     mem_ready;
  // statistics
  logic [31:0]              hit_count;
  logic [31:0]              miss_count;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_byteen, cpu_read, cpu_write,
    input  mem_rdata, mem_ready,
    output cpu_rdata, gen_stall,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output hit_count, miss_count
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_byteen, cpu_read, cpu_write,
    output mem_rdata, mem_ready,
    input  cpu_rdata, gen_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  hit_count, miss_count
  );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache for the
// MEM stage. Misses stall the pipeline combinationally; victim writeback and
// refill use a line-wide req/ready handshake.
// Optional: define DCACHE_STATS_EN to build hit/miss counters; otherwise
// hit_count/miss_count are tied to zero.
// Assumes LINE_WORDS >= 2 and NUM_LINES >= 2 (both powers of two).
module dcache_ctrl #(
  parameter int NUM_LINES  = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic     clk,
  input  logic     reset,
  dcache_if.slave  bus
);
  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int OFFS_W  = $clog2(LINE_WORDS) + 2;
  localparam int TAG_W   = 32 - INDEX_W - OFFS_W;
  localparam int WSEL_W  = OFFS_W - 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WB    = 2'd1;
  localparam logic [1:0] S_ALLOC = 2'd2;

  // state and arrays
  logic [1:0]                   r_state;
  logic [NUM_LINES-1:0]         r_valid;
  logic [NUM_LINES-1:0]         r_dirty;
  logic [TAG_W-1:0]             r_tag  [NUM_LINES];
  logic [LINE_WORDS-1:0][31:0]  r_data [NUM_LINES];
  // miss context latched at detection so a flushed request cannot disturb it
  logic [INDEX_W-1:0]           r_idx;
  logic [TAG_W-1:0]             r_req_tag;
  logic [31:0]                  r_mem_addr;

  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_index;
  logic [WSEL_W-1:0]  w_word;
  logic               w_access;
  logic               w_hit;
  logic               w_miss;
  logic               w_wr_hit;
  logic               w_dirty_set;
  logic               w_victim_dirty;
  logic               w_fill;
  logic [31:0]        w_rword;
  logic [31:0]        w_wword;
  logic [1:0]         w_unused_lsb;

  assign w_tag          = bus.cpu_addr[31 -: TAG_W];
  assign w_index        = bus.cpu_addr[OFFS_W +: INDEX_W];
  assign w_word         = bus.cpu_addr[2 +: WSEL_W];
  assign w_unused_lsb   = bus.cpu_addr[1:0];

  assign w_access       = bus.cpu_read | bus.cpu_write;
  assign w_hit          = (r_state == S_IDLE) & r_valid[w_index] &
                          (r_tag[w_index] == w_tag);
  assign w_miss         = (r_state == S_IDLE) & w_access & ~w_hit;
  // read+write together is treated as a write
  assign w_wr_hit       = w_hit & bus.cpu_write;
  assign w_dirty_set    = w_wr_hit & (|bus.cpu_byteen);
  assign w_victim_dirty = r_valid[w_index] & r_dirty[w_index];
  assign w_fill         = (r_state == S_ALLOC) & bus.mem_ready;

  assign w_rword        = r_data[w_index][w_word];

  // byte-lane merge of store data over the currently stored word
  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign w_wword[8*b +: 8] = bus.cpu_byteen[b] ? bus.cpu_wdata[8*b +: 8]
                                                 : w_rword[8*b +: 8];
  end

  assign bus.cpu_rdata = w_hit ? w_rword : 32'd0;
  assign bus.gen_stall = w_access & ~w_hit;

  assign bus.mem_req   = (r_state == S_WB) | (r_state == S_ALLOC);
  assign bus.mem_we    = (r_state == S_WB);
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = (r_state == S_WB) ? r_data[r_idx] : '0;

  // miss FSM: IDLE -> (WB) -> ALLOC -> IDLE, memory address registered per phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_req_tag  <= '0;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_miss) begin
            r_idx     <= w_index;
            r_req_tag <= w_tag;
            if (w_victim_dirty) begin
              r_state    <= S_WB;
              r_mem_addr <= {r_tag[w_index], w_index, {OFFS_W{1'b0}}};
            end else begin
              r_state    <= S_ALLOC;
              r_mem_addr <= {w_tag, w_index, {OFFS_W{1'b0}}};
            end
          end
        end
        S_WB: begin
          if (bus.mem_ready) begin
            r_state    <= S_ALLOC;
            r_mem_addr <= {r_req_tag, r_idx, {OFFS_W{1'b0}}};
          end
        end
        S_ALLOC: begin
          if (bus.mem_ready) begin
            r_state    <= S_IDLE;
            r_mem_addr <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // line status: refill validates and cleans, a store with any byte enabled dirties
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (w_fill) begin
      r_valid[r_idx] <= 1'b1;
      r_dirty[r_idx] <= 1'b0;
    end else if (w_dirty_set) begin
      r_dirty[w_index] <= 1'b1;
    end
  end

  // tag/data arrays: refill writes a whole line, store hit writes one merged word
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[r_idx] <= bus.mem_rdata;
      r_tag[r_idx]  <= r_req_tag;
    end else if (w_wr_hit) begin
      r_data[w_index][w_word] <= w_wword;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // hits count every hitting cycle; misses count once on leaving IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_access & w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_miss)           r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign bus.hit_count  = r_hit_cnt;
  assign bus.miss_count = r_miss_cnt;
`else
  assign bus.hit_count  = 32'd0;
  assign bus.miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: table-driven accesses against a line-wide memory responder,
// with a read-data scoreboard queue and hand sequences for writeback stall
// and reset during refill.
module tb_dcache_ctrl;
  logic clk;
  logic reset;

  dcache_if #(.LINE_WORDS(4)) bus();

  dcache_ctrl #(.NUM_LINES(64), .LINE_WORDS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        rd;
    logic        wr;
    logic        exp_miss;
    logic        exp_wb;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vtab [14];
  logic [31:0] exp_q [$];
  logic [127:0] mem_store [logic [31:0]];
  int n_chk  = 0;
  int n_pass = 0;
  int lat    = 1;
  int wcnt   = 0;
  int m_acc  = 0;
  int m_miss = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] exp_cnt(input int v);
`ifdef DCACHE_STATS_EN
    return 32'(v);
`else
    return 32'd0 & 32'(v);
`endif
  endfunction

  // untouched memory: word at byte address a reads 0xC0DE_0000 | a[15:0]
  function automatic logic [127:0] line_rd(input logic [31:0] a);
    logic [127:0] r;
    logic [15:0]  lo;
    if (mem_store.exists(a)) return mem_store[a];
    for (int k = 0; k < 4; k++) begin
      lo = a[15:0] + 16'(4 * k);
      r[32*k +: 32] = {16'hC0DE, lo};
    end
    return r;
  endfunction

  // memory responder: ready pulses after 'lat' request cycles
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (reset || bus.mem_ready) begin
        bus.mem_ready = 1'b0;
        wcnt = 0;
      end else if (bus.mem_req) begin
        if (wcnt < lat) wcnt++;
        else begin
          if (bus.mem_we) mem_store[bus.mem_addr] = bus.mem_wdata;
          else            bus.mem_rdata = line_rd(bus.mem_addr);
          bus.mem_ready = 1'b1;
          wcnt = 0;
        end
      end else wcnt = 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                           input logic rd, input logic wr, input logic exp_miss,
                           input logic exp_wb, input logic [31:0] exp_rd, input string nm);
    logic saw_wb;
    logic [31:0] e;
    int n;
    @(negedge clk);
    bus.cpu_addr = a; bus.cpu_wdata = wd; bus.cpu_byteen = be;
    bus.cpu_read = rd; bus.cpu_write = wr;
    #1;
    check({nm, " stall"}, 32'(bus.gen_stall), 32'(exp_miss));
    if (rd && !wr) exp_q.push_back(exp_rd);
    saw_wb = 1'b0;
    n = 0;
    while (bus.gen_stall && n < 300) begin
      @(negedge clk); #1;
      if (bus.mem_req && bus.mem_we) saw_wb = 1'b1;
      n++;
    end
    if (bus.gen_stall) check({nm, " timeout"}, 32'(bus.gen_stall), 32'd0);
    check({nm, " wb"}, 32'(saw_wb), 32'(exp_wb));
    if (rd && !wr) begin
      if (exp_q.size() == 0) check({nm, " queue"}, 32'd0, 32'd1);
      else begin
        e = exp_q.pop_front();
        check({nm, " rdata"}, bus.cpu_rdata, e);
      end
    end
    m_acc++;
    if (exp_miss) m_miss++;
    @(posedge clk); #1;
    bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
  endtask

  initial begin
    logic [31:0] e;
    logic [127:0] wline;
    int n;
    vtab[0]  = '{32'h0000_0100, 32'h0,         4'h0, 1, 0, 1, 0, 32'h0000_0001};
    vtab[1]  = '{32'h0000_0104, 32'h0,         4'h0, 1, 0, 0, 0, 32'h0000_0002};
    vtab[2]  = '{32'h0000_0100, 32'hAABBCCDD, 4'h3, 0, 1, 0, 0, 32'h0};
    vtab[3]  = '{32'h0000_0100, 32'h0,         4'h0, 1, 0, 0, 0, 32'h0000_CCDD};
    vtab[4]  = '{32'h0000_0108, 32'h11223344, 4'hF, 1, 1, 0, 0, 32'h0};
    vtab[5]  = '{32'h0000_0108, 32'h0,         4'h0, 1, 0, 0, 0, 32'h1122_3344};
    vtab[6]  = '{32'h0000_010C, 32'hFFFFFFFF, 4'h0, 0, 1, 0, 0, 32'h0};
    vtab[7]  = '{32'h0000_010C, 32'h0,         4'h0, 1, 0, 0, 0, 32'h0000_0004};
    vtab[8]  = '{32'h0000_0200, 32'h0,         4'h0, 1, 0, 1, 0, 32'hC0DE_0200};
    vtab[9]  = '{32'h0000_0204, 32'hFFFFFFFF, 4'h0, 0, 1, 0, 0, 32'h0};
    vtab[10] = '{32'h0000_1200, 32'h0,         4'h0, 1, 0, 1, 0, 32'hC0DE_1200};
    vtab[11] = '{32'h0000_0304, 32'hDEADBEEF, 4'hF, 0, 1, 1, 0, 32'h0};
    vtab[12] = '{32'h0000_0304, 32'h0,         4'h0, 1, 0, 0, 0, 32'hDEAD_BEEF};
    vtab[13] = '{32'h0000_1304, 32'h0,         4'h0, 1, 0, 1, 1, 32'hC0DE_1304};

    mem_store[32'h100] = {32'd4, 32'd3, 32'd2, 32'd1};

    reset = 1'b1;
    bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_byteen = '0;
    bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst stall",    32'(bus.gen_stall), 32'd0);
    check("rst mem_req",  32'(bus.mem_req),   32'd0);
    check("rst mem_we",   32'(bus.mem_we),    32'd0);
    check("rst mem_addr", bus.mem_addr,       32'd0);
    check("rst rdata",    bus.cpu_rdata,      32'd0);
    check("rst hits",     bus.hit_count,      32'd0);
    check("rst misses",   bus.miss_count,     32'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      do_access(vtab[i].addr, vtab[i].wdata, vtab[i].be, vtab[i].rd, vtab[i].wr,
                vtab[i].exp_miss, vtab[i].exp_wb, vtab[i].exp_rdata, $sformatf("vec%0d", i));
      if (i == 1) begin
        check("first hits",   bus.hit_count,  exp_cnt(2));
        check("first misses", bus.miss_count, exp_cnt(1));
      end
    end

    // dirty victim 0x100 evicted by 0x1100 with a slow memory
    lat = 5;
    @(negedge clk);
    bus.cpu_addr = 32'h0000_1100; bus.cpu_read = 1'b1;
    #1;
    check("wb detect stall", 32'(bus.gen_stall), 32'd1);
    exp_q.push_back(32'hC0DE_1100);
    @(negedge clk); #1;
    check("wb mem_req",  32'(bus.mem_req), 32'd1);
    check("wb mem_we",   32'(bus.mem_we),  32'd1);
    check("wb mem_addr", bus.mem_addr,     32'h0000_0100);
    wline = bus.mem_wdata;
    check("wb word0",    wline[31:0],      32'h0000_CCDD);
    check("wb word2",    wline[95:64],     32'h1122_3344);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check($sformatf("wb hold stall %0d", c), 32'(bus.gen_stall), 32'd1);
      check($sformatf("wb hold addr %0d", c),  bus.mem_addr,       32'h0000_0100);
    end
    n = 0;
    while (!(bus.mem_req && !bus.mem_we) && n < 50) begin @(negedge clk); #1; n++; end
    check("alloc seen",     32'(bus.mem_req && !bus.mem_we), 32'd1);
    check("alloc mem_addr", bus.mem_addr, 32'h0000_1100);
    n = 0;
    while (bus.gen_stall && n < 50) begin @(negedge clk); #1; n++; end
    check("wb end stall", 32'(bus.gen_stall), 32'd0);
    e = exp_q.pop_front();
    check("wb rdata", bus.cpu_rdata, e);
    m_acc++; m_miss++;
    @(posedge clk); #1;
    bus.cpu_read = 1'b0;
    lat = 1;

    // written-back data comes back from memory
    do_access(32'h0000_0100, 32'h0, 4'h0, 1, 0, 1, 0, 32'h0000_CCDD, "reload100");
    do_access(32'h0000_0108, 32'h0, 4'h0, 1, 0, 0, 0, 32'h1122_3344, "hit108");
    do_access(32'h0000_0304, 32'h0, 4'h0, 1, 0, 1, 0, 32'hDEAD_BEEF, "reload304");
    check("total hits",   bus.hit_count,  exp_cnt(m_acc));
    check("total misses", bus.miss_count, exp_cnt(m_miss));

    // reset in the middle of a refill
    lat = 10;
    @(negedge clk);
    bus.cpu_addr = 32'h0000_2100; bus.cpu_read = 1'b1;
    #1;
    check("rst2 detect stall", 32'(bus.gen_stall), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check("rst2 alloc req",  32'(bus.mem_req), 32'd1);
    check("rst2 alloc we",   32'(bus.mem_we),  32'd0);
    check("rst2 alloc addr", bus.mem_addr,     32'h0000_2100);
    #2 reset = 1'b1;
    #1;
    check("rst2 mem_req",  32'(bus.mem_req), 32'd0);
    check("rst2 mem_addr", bus.mem_addr,     32'd0);
    bus.cpu_read = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    lat = 1;
    check("rst2 hits",   bus.hit_count,  32'd0);
    check("rst2 misses", bus.miss_count, 32'd0);
    do_access(32'h0000_0104, 32'h0, 4'h0, 1, 0, 1, 0, 32'h0000_0002, "after rst 104");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
